// File: rtl/writeback_stage_pkg.sv
// Shared pipeline register types and writeback helpers used by the ALU stage,
// the writeback stage and hazard logic.
package writeback_stage_pkg;

  localparam int EX_WB_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [EX_WB_XLEN-1:0] alu_result;
    logic                  alu_result_ready;
    logic [4:0]            reg_wr_addr;
    logic                  rd_wr_en;
    logic                  do_not_execute;
  } EX_WB;

  // True when this EX_WB entry will actually update the register file.
  function automatic logic wb_commit(input EX_WB e);
    return e.alu_result_ready & ~e.do_not_execute & e.rd_wr_en &
           (e.reg_wr_addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Execute/writeback boundary: EX_WB register and source addresses in,
// bypassed ALU operands out.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  // No handshake: the ALU stage presents one EX_WB per cycle and the
  // writeback stage always consumes it; operands are combinational returns.
  EX_WB                  ex_wb_r;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [EX_WB_XLEN-1:0] alu_reg_input_a;
  logic [EX_WB_XLEN-1:0] alu_reg_input_b;

  modport master (
    output ex_wb_r, rs1_addr, rs2_addr,
    input  alu_reg_input_a, alu_reg_input_b
  );

  modport slave (
    input  ex_wb_r, rs1_addr, rs2_addr,
    output alu_reg_input_a, alu_reg_input_b
  );

endinterface

// File: rtl/writeback_stage_register_file.sv
// 31 x XLEN integer register file, one write port and two combinational read
// ports; x0 has no storage and always reads zero.
module register_file
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = EX_WB_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [1:31];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == REG_ZERO) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == REG_ZERO) ? '0 : regs[raddr_b];

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits EX_WB results, bypasses them to the ALU
// operands, counts retired instructions and keeps a registered commit trace.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN      = EX_WB_XLEN,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  writeback_stage_if.slave     bus,
  output logic [INSTRET_W-1:0] instret,
  output logic                 wb_valid,
  output logic [4:0]           wb_addr,
  output logic [XLEN-1:0]      wb_data
);

  logic            retire;
  logic            commit;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;

  assign retire = bus.ex_wb_r.alu_result_ready & ~bus.ex_wb_r.do_not_execute;
  assign commit = wb_commit(bus.ex_wb_r);

  register_file #(.XLEN(XLEN)) u_register_file (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (commit),
    .waddr   (bus.ex_wb_r.reg_wr_addr),
    .wdata   (bus.ex_wb_r.alu_result),
    .raddr_a (bus.rs1_addr),
    .rdata_a (rf_a),
    .raddr_b (bus.rs2_addr),
    .rdata_b (rf_b)
  );

  // Same-cycle bypass so a dependent instruction right behind its producer
  // sees the new value without a stall.
  always_comb begin
    bus.alu_reg_input_a = rf_a;
    bus.alu_reg_input_b = rf_b;
    if (bus.rs1_addr == REG_ZERO)
      bus.alu_reg_input_a = '0;
    else if (commit && (bus.ex_wb_r.reg_wr_addr == bus.rs1_addr))
      bus.alu_reg_input_a = bus.ex_wb_r.alu_result;
    if (bus.rs2_addr == REG_ZERO)
      bus.alu_reg_input_b = '0;
    else if (commit && (bus.ex_wb_r.reg_wr_addr == bus.rs2_addr))
      bus.alu_reg_input_b = bus.ex_wb_r.alu_result;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + INSTRET_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= commit;
      if (commit) begin
        wb_addr <= bus.ex_wb_r.reg_wr_addr;
        wb_data <= bus.ex_wb_r.alu_result;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed literal checks plus randomized traffic
// compared every cycle against a behavioural register-file/counter model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [63:0] instret;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  instret_s;
  logic        wb_valid_s;
  logic [4:0]  wb_addr_s;
  logic [31:0] wb_data_s;

  writeback_stage_if bus ();
  writeback_stage_if bus_s ();

  writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .instret(instret), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  // Narrow counter instance so the wrap-around is reachable quickly.
  writeback_stage #(.XLEN(32), .INSTRET_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .bus(bus_s.slave),
    .instret(instret_s), .wb_valid(wb_valid_s), .wb_addr(wb_addr_s), .wb_data(wb_data_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic        m_wb_valid;
  logic [36:0] exp_q [$];

  function automatic logic m_commits(input EX_WB e);
    return e.alu_result_ready && !e.do_not_execute && e.rd_wr_en && e.reg_wr_addr != 0;
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (m_commits(bus.ex_wb_r) && bus.ex_wb_r.reg_wr_addr == rs) return bus.ex_wb_r.alu_result;
    return m_regs[rs];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instret  = '0;
    m_wb_valid = 1'b0;
    exp_q.delete();
  endtask

  initial model_clear();
  always @(negedge reset_n) model_clear();

  always @(posedge clk) begin
    if (reset_n) begin
      m_wb_valid = m_commits(bus.ex_wb_r);
      if (bus.ex_wb_r.alu_result_ready && !bus.ex_wb_r.do_not_execute) m_instret++;
      if (m_wb_valid) begin
        m_regs[bus.ex_wb_r.reg_wr_addr] = bus.ex_wb_r.alu_result;
        exp_q.push_back({bus.ex_wb_r.reg_wr_addr, bus.ex_wb_r.alu_result});
      end
    end
  end

  // compare process, every cycle on the falling edge
  logic [36:0] trace_exp;
  always @(negedge clk) begin
    check("op_a", bus.alu_reg_input_a, m_operand(bus.rs1_addr));
    check("op_b", bus.alu_reg_input_b, m_operand(bus.rs2_addr));
    check("instret", instret, m_instret);
    check("wb_valid", wb_valid, m_wb_valid);
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        check("trace_unexpected", 1, 0);
      end else begin
        trace_exp = exp_q.pop_front();
        check("trace", {wb_addr, wb_data}, trace_exp);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [31:0] res, input logic rdy, input logic [4:0] addr,
                       input logic wen, input logic dne, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    bus.ex_wb_r.alu_result       = res;
    bus.ex_wb_r.alu_result_ready = rdy;
    bus.ex_wb_r.reg_wr_addr      = addr;
    bus.ex_wb_r.rd_wr_en         = wen;
    bus.ex_wb_r.do_not_execute   = dne;
    bus.rs1_addr                 = rs1;
    bus.rs2_addr                 = rs2;
  endtask

  task automatic bubble(input logic [4:0] rs1, input logic [4:0] rs2);
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, rs1, rs2);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  r_addr;
  logic [31:0] r_res;

  initial begin
    reset_n = 1'b0;
    bubble(5'd5, 5'd0);
    bus_s.ex_wb_r = '0;
    bus_s.rs1_addr = 5'd0;
    bus_s.rs2_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instret", instret, 64'd0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_op_a", bus.alu_reg_input_a, 32'h0);
    reset_n = 1'b1;
    next_cycle();

    // preload x5, then asynchronous reset mid-cycle
    drive(32'h1234, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd0);
    @(negedge clk);
    check("x5_bypass", bus.alu_reg_input_a, 32'h1234);
    next_cycle();
    bubble(5'd5, 5'd0);
    @(negedge clk);
    check("x5_stored", bus.alu_reg_input_a, 32'h1234);
    check("x5_instret", instret, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_x5", bus.alu_reg_input_a, 32'h0);
    check("async_instret", instret, 64'd0);
    check("async_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // basic commit with bypass
    drive(32'hDEAD0001, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 5'd0);
    @(negedge clk);
    check("basic_bypass", bus.alu_reg_input_a, 32'hDEAD0001);
    next_cycle();
    bubble(5'd7, 5'd0);
    @(negedge clk);
    check("basic_reg", bus.alu_reg_input_a, 32'hDEAD0001);
    check("basic_wb_valid", wb_valid, 1'b1);
    check("basic_wb_addr", wb_addr, 5'd7);
    check("basic_instret", instret, 64'd1);
    next_cycle();

    // write to x0
    drive(32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    check("x0_op_a", bus.alu_reg_input_a, 32'h0);
    check("x0_op_b", bus.alu_reg_input_b, 32'h0);
    next_cycle();
    bubble(5'd0, 5'd0);
    @(negedge clk);
    check("x0_wb_valid", wb_valid, 1'b0);
    check("x0_instret", instret, 64'd2);
    check("x0_hold_addr", wb_addr, 5'd7);
    check("x0_hold_data", wb_data, 32'hDEAD0001);
    next_cycle();

    // squash over x3=0x11
    drive(32'h11, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
    next_cycle();
    drive(32'h55, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 5'd3);
    @(negedge clk);
    check("squash_op_a", bus.alu_reg_input_a, 32'h11);
    next_cycle();
    bubble(5'd3, 5'd0);
    @(negedge clk);
    check("squash_reg", bus.alu_reg_input_a, 32'h11);
    check("squash_instret", instret, 64'd3);
    check("squash_wb_valid", wb_valid, 1'b0);
    next_cycle();

    // dual-port hit, then the same with result not ready
    drive(32'hA5A5, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 5'd9);
    @(negedge clk);
    check("dual_a", bus.alu_reg_input_a, 32'hA5A5);
    check("dual_b", bus.alu_reg_input_b, 32'hA5A5);
    next_cycle();
    drive(32'hBEEF, 1'b0, 5'd9, 1'b1, 1'b0, 5'd9, 5'd9);
    @(negedge clk);
    check("notready_a", bus.alu_reg_input_a, 32'hA5A5);
    check("notready_b", bus.alu_reg_input_b, 32'hA5A5);
    next_cycle();
    bubble(5'd9, 5'd0);
    @(negedge clk);
    check("notready_instret", instret, 64'd4);
    check("notready_wb_valid", wb_valid, 1'b0);
    next_cycle();

    // counter wrap on the narrow instance
    bus_s.ex_wb_r.alu_result_ready = 1'b1;
    bus_s.ex_wb_r.rd_wr_en = 1'b1;
    bus_s.ex_wb_r.reg_wr_addr = 5'd1;
    repeat (15) next_cycle();
    check("wrap_all_ones", instret_s, 4'hF);
    next_cycle();
    check("wrap_zero", instret_s, 4'h0);
    bus_s.ex_wb_r = '0;

    // randomized traffic
    for (int n = 0; n < 1000; n++) begin
      r_addr = 5'($urandom_range(0, 31));
      r_res  = $urandom();
      drive(r_res, $urandom_range(0, 3) != 0, r_addr, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0,
            ($urandom_range(0, 2) == 0) ? r_addr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? r_addr : 5'($urandom_range(0, 31)));
      next_cycle();
    end
    bubble(5'd0, 5'd0);
    repeat (2) next_cycle();
    check("trace_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

- Final pipeline stage. Consumes the `EX_WB` register driven by the ALU stage and commits results to the 32×32 integer register file.
- Supplies both ALU operands to the execute stage, with write-back bypass so a dependent instruction issued immediately behind its producer sees the new value.
- Maintains the retired-instruction counter and a registered commit trace for the testbench and debug.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `INSTRET_W`, 64: retired-instruction counter width.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ex_wb_r`  in  `EX_WB`  execute→writeback register. Fields used: `alu_result`, `alu_result_ready`, `reg_wr_addr`, `rd_wr_en`, `do_not_execute`.
- `rs1_addr`  in  5  source register A of the instruction currently in `ID_EX`.
- `rs2_addr`  in  5  source register B of the instruction currently in `ID_EX`.
- `alu_reg_input_a`  out  XLEN  operand A to the ALU stage (combinational).
- `alu_reg_input_b`  out  XLEN  operand B to the ALU stage (combinational).
- `instret`  out  INSTRET_W  count of retired instructions.
- `wb_valid`  out  1  registered: a register write committed last cycle.
- `wb_addr`  out  5  registered: destination of that write.
- `wb_data`  out  XLEN  registered: data of that write.

## Operation
Retire and commit conditions:
- `retire = ex_wb_r.alu_result_ready & ~ex_wb_r.do_not_execute`.
- `commit = retire & ex_wb_r.rd_wr_en & (ex_wb_r.reg_wr_addr != 0)`.

On each rising edge:
- If `commit`: `regs[reg_wr_addr] <= alu_result`.
- If `retire`: `instret` increments by 1, wrapping modulo 2^INSTRET_W. It is never saturated.
- Trace registers load `wb_valid <= commit`, `wb_addr <= reg_wr_addr`, `wb_data <= alu_result`. When `commit=0`, `wb_addr` and `wb_data` hold their previous values.

x0 handling:
- x0 reads as 0 in all cases.
- Writes to x0 are dropped; there is no storage for x0.
- A retire that writes x0 still increments `instret` but leaves `wb_valid=0`.

Operand read, per port (shown for A; B identical with `rs2_addr`):
- `rs1_addr == 0` → `alu_reg_input_a = 0`.
- Else if `commit & (reg_wr_addr == rs1_addr)` → `ex_wb_r.alu_result` (bypass).
- Else → `regs[rs1_addr]`.

Squashed and not-ready results:
- A squashed instruction (`do_not_execute=1`) never writes, never forwards and never retires, even when `rd_wr_en=1` and `alu_result_ready=1`.
- `alu_result_ready=0` (ALU_NONE, bubble): no write, no forward, no retire. `rd_wr_en` is ignored.

Dual-port hit: both ports addressing the same register as the pending write both receive the bypassed value.

Reset (asynchronous assertion):
- All 31 registers clear to 0.
- `instret`, `wb_valid`, `wb_addr` and `wb_data` clear to 0.
- A write pending in `ex_wb_r` at the moment reset asserts is discarded.
- Operand outputs follow combinationally: they read 0 while `ex_wb_r` is reset.

## Timing
- Write latency: a result present in `ex_wb_r` during cycle N is visible in `regs` from cycle N+1. It is visible on the operand outputs during cycle N via bypass.
- Net effect: zero-stall back-to-back dependency for ALU→ALU chains.
- `instret` and the trace outputs reflect cycle N's retire/commit in cycle N+1.
- Operand outputs are purely combinational from `rs*_addr`, `ex_wb_r` and `regs`. There is no other path from `ex_wb_r` to operands.
- No handshake or backpressure: the stage accepts one `EX_WB` per cycle unconditionally.
- First edge after reset deassertion may commit normally.

## Structure
- The `EX_WB` typedef stays in the shared pipeline register package. No new fields are added.
- Add to the shared package:
  - `REG_ZERO = 5'd0`.
  - `wb_commit(EX_WB)` function returning the commit condition, for reuse by hazard logic.
- Sub-module `register_file`:
  - Ports: `clk`, `reset_n`, 1 write port (`we`, `waddr`, `wdata`), 2 combinational read ports.
  - x0 hardwired to zero.
  - Contains no bypass logic.
- Bypass muxes, `instret` and trace registers live in `writeback_stage`.

## Test plan
- Reset: preload x5=0x1234 via commit, assert `reset_n=0` mid-cycle → x5 reads 0, `instret=0`, `wb_valid=0` immediately, with no clock edge needed.
- Basic commit: `ex_wb_r`={result 0xDEAD0001, ready 1, addr 7, wr_en 1, dne 0}, `rs1_addr=7` → operand A = 0xDEAD0001 in the same cycle (bypass). Next cycle with bubble input, A still 0xDEAD0001, `wb_valid=1`, `wb_addr=7`, `instret=1`.
- x0: commit result 0xFFFFFFFF to addr 0 with `rs1_addr=rs2_addr=0` → both operands 0, `wb_valid=0` next cycle, `instret` increments.
- Squash: result 0x55 to x3 with `do_not_execute=1` over prior x3=0x11 → operand reads 0x11 in both cycles, `instret` unchanged, `wb_valid=0`.
- Dual-port / not-ready: `rs1_addr=rs2_addr=9` with pending write 0xA5A5 to x9 → both operands 0xA5A5. Repeat with `alu_result_ready=0` → both operands show old x9, no retire.
- Wrap: force `instret` to all-ones, retire once → `instret=0`. Then 1000 random ALU results checked against a reference model of the register file and counter.
